// File: rtl/count_ext_monitor.sv
// count_ext_monitor: watches an up/down counter's output. It classifies every
// step, extends the count with a wrap field, and queues events
// (WRAP_UP/WRAP_DN/LOAD/THRESH/ILLEGAL) into a small valid/ready FIFO.
// Optional feature macro: MONITOR_MINMAX_EN adds the cnt_min/cnt_max outputs.
module count_ext_monitor #(
    parameter int W      = 8,
    parameter int EXT_W  = 8,
    parameter int THRESH = 200,
    parameter int DEPTH  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W-1:0]       count_in,
    input  logic               load_in,
    input  logic               updown_in,
    input  logic               clear_err,
    output logic [W+EXT_W-1:0] ext_count,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [2:0]         evt_code,
    output logic [W-1:0]       evt_value,
    output logic               ovf,
    output logic               err
`ifdef MONITOR_MINMAX_EN
    ,
    output logic [W-1:0]       cnt_min,
    output logic [W-1:0]       cnt_max
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [W-1:0] THR = W'(THRESH);
    localparam logic [W-1:0] MAXV = '1;
    localparam logic [2:0] C_WRAP_UP = 3'd0, C_WRAP_DN = 3'd1, C_LOAD = 3'd2,
                           C_THRESH = 3'd3, C_ILLEGAL = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_ERROR} state_t;
    typedef struct packed {
        logic [2:0]   code;
        logic [W-1:0] value;
    } evt_t;

    state_t             state_q, state_d;
    logic [W-1:0]       prev_q;
    logic               load_d_q, dir_d_q;
    logic [W+EXT_W-1:0] ext_q, ext_d;
    logic [EXT_W-1:0]   field;
    logic               push, cls_load, cls_illegal;
    evt_t               push_evt;

    evt_t               mem_q [DEPTH];
    evt_t               mem_d [DEPTH];
    logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]        cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               full, pop, push_ok, drop;

    assign field = ext_q[W+EXT_W-1:W];

    // Step classification and FSM next state; one class per TRACK cycle, highest priority first
    always_comb begin
        state_d        = state_q;
        ext_d          = ext_q;
        push           = 1'b0;
        cls_load       = 1'b0;
        cls_illegal    = 1'b0;
        push_evt.code  = C_WRAP_UP;
        push_evt.value = count_in;
        case (state_q)
            S_IDLE: begin
                ext_d   = {{EXT_W{1'b0}}, count_in};
                state_d = S_TRACK;
            end
            S_TRACK: begin
                if (load_d_q) begin
                    cls_load      = 1'b1;
                    push          = 1'b1;
                    push_evt.code = C_LOAD;
                    ext_d         = {{EXT_W{1'b0}}, count_in};
                end else if (dir_d_q && prev_q == MAXV && count_in == '0) begin
                    push          = 1'b1;
                    push_evt.code = C_WRAP_UP;
                    ext_d         = {field + EXT_W'(1), count_in};
                end else if (!dir_d_q && prev_q == '0 && count_in == MAXV) begin
                    push          = 1'b1;
                    push_evt.code = C_WRAP_DN;
                    ext_d         = {field - EXT_W'(1), count_in};
                end else if ((dir_d_q && count_in == prev_q + W'(1)) ||
                             (!dir_d_q && count_in == prev_q - W'(1)) ||
                             count_in == prev_q) begin
                    ext_d = {field, count_in};
                    if (count_in == THR && prev_q != THR) begin
                        push          = 1'b1;
                        push_evt.code = C_THRESH;
                    end
                end else begin
                    // ext_count stays frozen until software re-syncs via clear_err
                    cls_illegal   = 1'b1;
                    push          = 1'b1;
                    push_evt.code = C_ILLEGAL;
                    state_d       = S_ERROR;
                end
            end
            S_ERROR: begin
                if (clear_err) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign pop     = evt_valid && evt_ready;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    // Event FIFO bookkeeping; a pop in the same cycle frees room for a push into a full FIFO
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (push_ok) begin
            mem_d[wr_q] = push_evt;
            wr_d        = wr_q + AW'(1);
        end
        if (pop) rd_d = rd_q + AW'(1);
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        if (clear_err) ovf_d = 1'b0;
        if (drop)      ovf_d = 1'b1;
    end

    // All monitor state; reset discards everything including queued events
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            prev_q   <= '0;
            load_d_q <= 1'b0;
            dir_d_q  <= 1'b0;
            ext_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= count_in;
            load_d_q <= load_in;
            dir_d_q  <= updown_in;
            ext_q    <= ext_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            mem_q    <= mem_d;
        end
    end

    assign ext_count = ext_q;
    assign evt_valid = (cnt_q != '0);
    assign evt_code  = evt_valid ? mem_q[rd_q].code  : 3'd0;
    assign evt_value = evt_valid ? mem_q[rd_q].value : '0;
    assign ovf       = ovf_q;
    assign err       = (state_q == S_ERROR);

`ifdef MONITOR_MINMAX_EN
    logic [W-1:0] min_q, min_d, max_q, max_d;

    // Running min/max over tracked samples; restarted on LOAD or clear_err, frozen otherwise
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (state_q == S_TRACK && !cls_illegal) begin
            if (cls_load) begin
                min_d = '1;
                max_d = '0;
            end else begin
                if (count_in < min_q) min_d = count_in;
                if (count_in > max_q) max_d = count_in;
            end
        end
        if (clear_err) begin
            min_d = '1;
            max_d = '0;
        end
    end

    // Min/max registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign cnt_min = min_q;
    assign cnt_max = max_q;
`else
    logic unused_cls;
    assign unused_cls = cls_load ^ cls_illegal;
`endif

endmodule

// File: tb/tb_count_ext_monitor.sv
// Directed bench for count_ext_monitor: walks wrap, load, threshold, illegal,
// FIFO overflow and mid-run reset scenarios with hand-computed expectations.
module tb_count_ext_monitor;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  count_in;
    logic        load_in, updown_in, clear_err, evt_ready;
    logic [15:0] ext_count;
    logic        evt_valid, ovf, err;
    logic [2:0]  evt_code;
    logic [7:0]  evt_value;
`ifdef MONITOR_MINMAX_EN
    logic [7:0]  cnt_min, cnt_max;
`endif

    int tests = 0;
    int fails = 0;

    count_ext_monitor #(.W(8), .EXT_W(8), .THRESH(200), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .count_in(count_in), .load_in(load_in),
        .updown_in(updown_in), .clear_err(clear_err), .ext_count(ext_count),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_value(evt_value), .ovf(ovf), .err(err)
`ifdef MONITOR_MINMAX_EN
        , .cnt_min(cnt_min), .cnt_max(cnt_max)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one counter sample for the next edge, then sample just after it
    task automatic cyc(input logic [7:0] c, input logic ld, input logic dir);
        count_in  = c;
        load_in   = ld;
        updown_in = dir;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; count_in = 8'd0; load_in = 1'b0; updown_in = 1'b1;
        clear_err = 1'b0; evt_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ext", ext_count, 16'h0000);
        chk("rst_valid", evt_valid, 1'b0);
        chk("rst_code", evt_code, 3'd0);
        chk("rst_value", evt_value, 8'd0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b1;

        // T1: free up-count through wrap
        cyc(8'd0, 1'b0, 1'b1);
        chk("t1_sync_ext", ext_count, 16'h0000);
        for (int i = 1; i <= 200; i++) cyc(8'(i), 1'b0, 1'b1);
        chk("t1_thr_valid", evt_valid, 1'b1);
        chk("t1_thr_code", evt_code, 3'd3);
        chk("t1_thr_ext", ext_count, 16'h00C8);
        for (int i = 201; i <= 255; i++) cyc(8'(i), 1'b0, 1'b1);
        chk("t1_pre_wrap_valid", evt_valid, 1'b0);
        cyc(8'd0, 1'b0, 1'b1);
        chk("t1_wrap_ext", ext_count, 16'h0100);
        chk("t1_wrap_code", evt_code, 3'd0);
        chk("t1_wrap_value", evt_value, 8'd0);

        // T2: load 200 (THRESH suppressed), then 199->200 threshold
        cyc(8'd0, 1'b1, 1'b1);
        cyc(8'd200, 1'b0, 1'b1);
        chk("t2_load_code", evt_code, 3'd2);
        chk("t2_load_value", evt_value, 8'd200);
        chk("t2_load_ext", ext_count, 16'h00C8);
        cyc(8'd201, 1'b0, 1'b1);
        chk("t2_no_thresh", evt_valid, 1'b0);
        cyc(8'd201, 1'b1, 1'b1);
        cyc(8'd198, 1'b0, 1'b1);
        chk("t2_load198_ext", ext_count, 16'h00C6);
        cyc(8'd199, 1'b0, 1'b1);
        cyc(8'd200, 1'b0, 1'b1);
        chk("t2_thr_code", evt_code, 3'd3);
        chk("t2_thr_value", evt_value, 8'd200);
        cyc(8'd201, 1'b0, 1'b1);

        // T3: load 2 then count down through zero
        cyc(8'd201, 1'b1, 1'b0);
        cyc(8'd2, 1'b0, 1'b0);
        chk("t3_load_ext", ext_count, 16'h0002);
        cyc(8'd1, 1'b0, 1'b0);
        cyc(8'd0, 1'b0, 1'b0);
        cyc(8'd255, 1'b0, 1'b0);
        chk("t3_wrapdn_code", evt_code, 3'd1);
        chk("t3_wrapdn_value", evt_value, 8'd255);
        chk("t3_wrapdn_ext", ext_count, 16'hFFFF);

        // T4: illegal jump 10->50, freeze, clear and resync
        cyc(8'd255, 1'b1, 1'b1);
        cyc(8'd10, 1'b0, 1'b1);
        cyc(8'd50, 1'b0, 1'b1);
        chk("t4_ill_code", evt_code, 3'd4);
        chk("t4_ill_value", evt_value, 8'd50);
        chk("t4_err", err, 1'b1);
        chk("t4_ext_frozen", ext_count, 16'h000A);
        cyc(8'd51, 1'b0, 1'b1);
        cyc(8'd60, 1'b0, 1'b1);
        chk("t4_err_hold", err, 1'b1);
        chk("t4_ext_hold", ext_count, 16'h000A);
        chk("t4_no_evt", evt_valid, 1'b0);
        clear_err = 1'b1;
        cyc(8'd61, 1'b0, 1'b1);
        clear_err = 1'b0;
        chk("t4_err_clr", err, 1'b0);
        cyc(8'd62, 1'b0, 1'b1);
        chk("t4_resync_ext", ext_count, 16'h003E);
        cyc(8'd63, 1'b0, 1'b1);
        chk("t4_track_ext", ext_count, 16'h003F);

        // T5: fill FIFO with ready low, fifth event dropped
        evt_ready = 1'b0;
        cyc(8'd63, 1'b1, 1'b1);
        cyc(8'd199, 1'b0, 1'b1);
        cyc(8'd200, 1'b0, 1'b1);
        cyc(8'd200, 1'b1, 1'b1);
        cyc(8'd255, 1'b0, 1'b1);
        cyc(8'd0, 1'b0, 1'b1);
        chk("t5_full_no_ovf", ovf, 1'b0);
        chk("t5_wrap_ext", ext_count, 16'h0100);
        cyc(8'd1, 1'b1, 1'b1);
        cyc(8'd5, 1'b0, 1'b1);
        chk("t5_ovf", ovf, 1'b1);
        chk("t5_ext_after_load", ext_count, 16'h0005);
        chk("t5_head0_code", evt_code, 3'd2);
        chk("t5_head0_value", evt_value, 8'd199);
        evt_ready = 1'b1;
        cyc(8'd5, 1'b0, 1'b1);
        chk("t5_head1_code", evt_code, 3'd3);
        chk("t5_head1_value", evt_value, 8'd200);
        cyc(8'd5, 1'b0, 1'b1);
        chk("t5_head2_code", evt_code, 3'd2);
        chk("t5_head2_value", evt_value, 8'd255);
        cyc(8'd5, 1'b0, 1'b1);
        chk("t5_head3_code", evt_code, 3'd0);
        chk("t5_head3_value", evt_value, 8'd0);
        cyc(8'd5, 1'b0, 1'b1);
        chk("t5_empty", evt_valid, 1'b0);
        chk("t5_ovf_sticky", ovf, 1'b1);
        clear_err = 1'b1;
        cyc(8'd5, 1'b0, 1'b1);
        clear_err = 1'b0;
        chk("t5_ovf_clr", ovf, 1'b0);
        chk("t5_err_stays_low", err, 1'b0);

        // T6: asynchronous reset with an event queued and ovf set
        evt_ready = 1'b0;
        cyc(8'd5, 1'b1, 1'b1);
        cyc(8'd20, 1'b1, 1'b1);
        cyc(8'd21, 1'b1, 1'b1);
        cyc(8'd22, 1'b1, 1'b1);
        cyc(8'd23, 1'b1, 1'b1);
        cyc(8'd24, 1'b0, 1'b1);
        chk("t6_pre_valid", evt_valid, 1'b1);
        chk("t6_pre_ovf", ovf, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("t6_valid", evt_valid, 1'b0);
        chk("t6_ext", ext_count, 16'h0000);
        chk("t6_ovf", ovf, 1'b0);
        chk("t6_code", evt_code, 3'd0);
        #2 rst = 1'b1;
        cyc(8'd7, 1'b0, 1'b1);
        chk("t6_resync_ext", ext_count, 16'h0007);
        chk("t6_resync_valid", evt_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
